// File: rtl/gpu_bg_block_mover.sv
// Background-block mover: saves the dirty halfwords of an exported 16-pixel block
// to VRAM, then reloads the next block and hands it back with a one-cycle strobe.
module gpu_bg_block_mover (
    input  logic         clk,
    input  logic         i_nrst,
    input  logic [1:0]   i_saveBGBlock,
    input  logic [14:0]  i_saveAdr,
    input  logic [14:0]  i_loadAdr,
    input  logic [255:0] i_exportedBGBlock,
    input  logic [15:0]  i_exportedMSKBGBlock,
    output logic         o_busy,
    output logic         o_importBGBlockSingleClock,
    output logic [255:0] o_importedBGBlock,
    output logic         o_errOverrun,
    output logic         o_memReq,
    output logic         o_memWrite,
    output logic [17:0]  o_memAdr,
    output logic [31:0]  o_memWdata,
    output logic [3:0]   o_memBE,
    input  logic         i_memAck,
    input  logic         i_memRdValid,
    input  logic [31:0]  i_memRdata
);
    typedef enum logic [2:0] {ST_IDLE, ST_SAVE, ST_LOAD_REQ, ST_LOAD_WAIT, ST_IMPORT} state_t;

    state_t         state, state_next;
    logic [1:0]     prev_code, code;
    logic [14:0]    save_adr, load_adr;
    logic [255:0]   blk;
    logic [15:0]    rem_mask;
    logic [2:0]     rd_idx, beat;
    logic           trigger;
    logic           ld_wr, ld_rd, rd_first, drop_req, beat_en;
    logic [15:0]    wr_mask;
    logic [255:0]   wr_data;
    logic [14:0]    wr_adr, rd_adr;
    logic [2:0]     pick, rd_next;
    logic           pick_any;
    logic [1:0]     pair;

    // Reset gates the trigger so every output reads 0 while i_nrst is low.
    assign trigger = i_nrst & (i_saveBGBlock != 2'b00) & (prev_code == 2'b00);
    assign o_busy = trigger | (state != ST_IDLE);
    assign o_errOverrun = trigger & (state != ST_IDLE);
    assign o_importBGBlockSingleClock = (state == ST_IMPORT);
    assign beat_en = i_memRdValid & ((state == ST_LOAD_REQ) | (state == ST_LOAD_WAIT));

    // In IDLE the first request is built straight from the inputs so it goes out at T+1.
    assign wr_mask = (state == ST_IDLE) ? i_exportedMSKBGBlock : rem_mask;
    assign wr_data = (state == ST_IDLE) ? i_exportedBGBlock : blk;
    assign wr_adr  = (state == ST_IDLE) ? i_saveAdr : save_adr;
    assign rd_adr  = (state == ST_IDLE) ? i_loadAdr : load_adr;
    assign rd_next = rd_first ? 3'd0 : rd_idx + 3'd1;
    assign pair    = wr_mask[{pick, 1'b0} +: 2];

    always_comb begin
        pick = 3'd0;
        pick_any = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (wr_mask[2*k +: 2] != 2'b00) begin
                pick = 3'(k);
                pick_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_wr      = 1'b0;
        ld_rd      = 1'b0;
        rd_first   = 1'b0;
        drop_req   = 1'b0;
        case (state)
            ST_IDLE: if (trigger) begin
                if (i_saveBGBlock != 2'b01 && pick_any) begin
                    ld_wr = 1'b1;
                    state_next = ST_SAVE;
                end else if (i_saveBGBlock != 2'b11) begin
                    ld_rd = 1'b1;
                    rd_first = 1'b1;
                    state_next = ST_LOAD_REQ;
                end
            end
            ST_SAVE: if (i_memAck) begin
                if (pick_any) begin
                    ld_wr = 1'b1;
                end else if (code == 2'b10) begin
                    ld_rd = 1'b1;
                    rd_first = 1'b1;
                    state_next = ST_LOAD_REQ;
                end else begin
                    drop_req = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD_REQ: begin
                if (i_memAck) begin
                    if (rd_idx == 3'd7) begin
                        drop_req = 1'b1;
                        state_next = ST_LOAD_WAIT;
                    end else begin
                        ld_rd = 1'b1;
                    end
                end
                if (beat_en && beat == 3'd7) state_next = ST_IMPORT;
            end
            ST_LOAD_WAIT: if (beat_en && beat == 3'd7) state_next = ST_IMPORT;
            ST_IMPORT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            prev_code         <= 2'b00;
            code              <= 2'b00;
            save_adr          <= '0;
            load_adr          <= '0;
            blk               <= '0;
            rem_mask          <= '0;
            rd_idx            <= '0;
            beat              <= '0;
            o_importedBGBlock <= '0;
            o_memReq          <= 1'b0;
            o_memWrite        <= 1'b0;
            o_memAdr          <= '0;
            o_memWdata        <= '0;
            o_memBE           <= '0;
        end else begin
            prev_code <= i_saveBGBlock;
            if (state == ST_IDLE && trigger) begin
                code     <= i_saveBGBlock;
                save_adr <= i_saveAdr;
                load_adr <= i_loadAdr;
                blk      <= i_exportedBGBlock;
            end
            if (ld_wr) begin
                rem_mask   <= wr_mask & ~(16'h0003 << {pick, 1'b0});
                o_memReq   <= 1'b1;
                o_memWrite <= 1'b1;
                o_memAdr   <= {wr_adr, pick};
                o_memWdata <= wr_data[{pick, 5'b0} +: 32];
                o_memBE    <= {pair[1], pair[1], pair[0], pair[0]};
            end else if (ld_rd) begin
                rd_idx     <= rd_next;
                o_memReq   <= 1'b1;
                o_memWrite <= 1'b0;
                o_memAdr   <= {rd_adr, rd_next};
                o_memWdata <= '0;
                o_memBE    <= '0;
            end else if (drop_req) begin
                o_memReq   <= 1'b0;
                o_memWrite <= 1'b0;
            end
            if (ld_rd && rd_first) beat <= 3'd0;
            if (beat_en) begin
                o_importedBGBlock[{beat, 5'b0} +: 32] <= i_memRdata;
                beat <= beat + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_gpu_bg_block_mover.sv
// Directed bench for gpu_bg_block_mover with a small VRAM/arbiter model.
module tb_gpu_bg_block_mover;
    logic         clk;
    logic         i_nrst;
    logic [1:0]   i_saveBGBlock;
    logic [14:0]  i_saveAdr, i_loadAdr;
    logic [255:0] i_exportedBGBlock;
    logic [15:0]  i_exportedMSKBGBlock;
    logic         o_busy, o_importBGBlockSingleClock, o_errOverrun;
    logic [255:0] o_importedBGBlock;
    logic         o_memReq, o_memWrite;
    logic [17:0]  o_memAdr;
    logic [31:0]  o_memWdata;
    logic [3:0]   o_memBE;
    logic         i_memAck, i_memRdValid;
    logic [31:0]  i_memRdata;

    gpu_bg_block_mover dut (
        .clk(clk), .i_nrst(i_nrst), .i_saveBGBlock(i_saveBGBlock),
        .i_saveAdr(i_saveAdr), .i_loadAdr(i_loadAdr),
        .i_exportedBGBlock(i_exportedBGBlock), .i_exportedMSKBGBlock(i_exportedMSKBGBlock),
        .o_busy(o_busy), .o_importBGBlockSingleClock(o_importBGBlockSingleClock),
        .o_importedBGBlock(o_importedBGBlock), .o_errOverrun(o_errOverrun),
        .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memAdr(o_memAdr),
        .o_memWdata(o_memWdata), .o_memBE(o_memBE), .i_memAck(i_memAck),
        .i_memRdValid(i_memRdValid), .i_memRdata(i_memRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0, nerr = 0;
    int edge_n = 0, wr_n = 0, rd_n = 0, imp_n = 0, imp_edge = 0, stall_err = 0;
    int t_edge;
    bit stall_en = 1'b0, mem_ready = 1'b0;
    logic [31:0] mem [0:1023];
    logic [17:0] wr_adr_q[$];
    logic [3:0]  wr_be_q[$];
    logic [31:0] wr_dat_q[$];
    logic [17:0] rd_adr_q[$];
    int          rd_edge_q[$];
    logic        p_stall;
    logic [54:0] p_fields;

    always @(negedge clk) i_memAck = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

    // VRAM model: zero-wait or random-stall acks, read data one cycle after the ack.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!i_nrst) begin
            i_memRdValid <= 1'b0;
            p_stall = 1'b0;
            if (!mem_ready) begin
                for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
                for (int i = 0; i < 8; i++) mem[32'h208 + i] = 32'h1111_1111 * i;
                mem_ready = 1'b1;
            end
        end else begin
            i_memRdValid <= 1'b0;
            if (p_stall && (!o_memReq || p_fields != {o_memWrite, o_memAdr, o_memWdata, o_memBE}))
                stall_err = stall_err + 1;
            p_stall = o_memReq && !i_memAck;
            p_fields = {o_memWrite, o_memAdr, o_memWdata, o_memBE};
            if (o_memReq && i_memAck) begin
                if (o_memWrite) begin
                    for (int b = 0; b < 4; b++)
                        if (o_memBE[b]) mem[o_memAdr[9:0]][8*b +: 8] = o_memWdata[8*b +: 8];
                    wr_adr_q.push_back(o_memAdr);
                    wr_be_q.push_back(o_memBE);
                    wr_dat_q.push_back(o_memWdata);
                    wr_n = wr_n + 1;
                end else begin
                    i_memRdValid <= 1'b1;
                    i_memRdata   <= mem[o_memAdr[9:0]];
                    rd_adr_q.push_back(o_memAdr);
                    rd_edge_q.push_back(edge_n);
                    rd_n = rd_n + 1;
                end
            end
            if (o_importBGBlockSingleClock) begin
                imp_n = imp_n + 1;
                imp_edge = edge_n;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c);
        @(negedge clk);
        i_saveBGBlock = c;
        t_edge = edge_n + 1;
        @(negedge clk);
        i_saveBGBlock = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 256'(o_busy), 256'(0));
    endtask

    initial begin
        logic [255:0] blk1, blk4;
        int w0, r0, i0;
        for (int n = 0; n < 8; n++) begin
            blk1[32*n +: 32] = 32'h1111_1111 * n;
            blk4[32*n +: 32] = 32'hC0DE_0000 + 32'h0101 * n;
        end
        i_nrst = 1'b0;
        i_saveBGBlock = 2'b00;
        i_saveAdr = '0;
        i_loadAdr = '0;
        i_exportedBGBlock = '0;
        i_exportedMSKBGBlock = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", 256'(o_memReq), 256'(0));
        chk("rst_busy", 256'(o_busy), 256'(0));
        chk("rst_imported", o_importedBGBlock, 256'(0));
        chk("rst_adr", 256'({o_memWrite, o_memAdr, o_memWdata, o_memBE}), 256'(0));
        i_nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Load only from block 0x41
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        i_loadAdr = 15'h0041;
        run_cmd(2'b01);
        wait_idle("t1_idle");
        chk("t1_reads", 256'(rd_n - r0), 256'(8));
        chk("t1_writes", 256'(wr_n - w0), 256'(0));
        chk("t1_first_adr", 256'(rd_adr_q[r0]), 256'(18'h00208));
        chk("t1_last_adr", 256'(rd_adr_q[r0 + 7]), 256'(18'h0020F));
        chk("t1_first_edge", 256'(rd_edge_q[r0]), 256'(t_edge + 1));
        chk("t1_imports", 256'(imp_n - i0), 256'(1));
        chk("t1_import_edge", 256'(imp_edge), 256'(t_edge + 10));
        chk("t1_word1", 256'(o_importedBGBlock[63:32]), 256'(32'h1111_1111));
        chk("t1_block", o_importedBGBlock, blk1);

        // Flush with mask 0x8001: two partial writes, no load
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        i_saveAdr = 15'h0003;
        i_exportedMSKBGBlock = 16'h8001;
        for (int n = 0; n < 8; n++) i_exportedBGBlock[32*n +: 32] = 32'hA5A5_0000 + n;
        run_cmd(2'b11);
        @(negedge clk);
        chk("t2_busy_t2", 256'(o_busy), 256'(1));
        @(negedge clk);
        chk("t2_busy_t3", 256'(o_busy), 256'(0));
        wait_idle("t2_idle");
        chk("t2_writes", 256'(wr_n - w0), 256'(2));
        chk("t2_adr0", 256'(wr_adr_q[w0]), 256'(18'h18));
        chk("t2_be0", 256'(wr_be_q[w0]), 256'(4'b0011));
        chk("t2_dat0", 256'(wr_dat_q[w0]), 256'(32'hA5A5_0000));
        chk("t2_adr1", 256'(wr_adr_q[w0 + 1]), 256'(18'h1F));
        chk("t2_be1", 256'(wr_be_q[w0 + 1]), 256'(4'b1100));
        chk("t2_dat1", 256'(wr_dat_q[w0 + 1]), 256'(32'hA5A5_0007));
        chk("t2_reads", 256'(rd_n - r0), 256'(0));
        chk("t2_imports", 256'(imp_n - i0), 256'(0));

        // Save+load with empty mask, same block
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        i_saveAdr = 15'h0041;
        i_loadAdr = 15'h0041;
        i_exportedMSKBGBlock = 16'h0000;
        run_cmd(2'b10);
        wait_idle("t3_idle");
        chk("t3_writes", 256'(wr_n - w0), 256'(0));
        chk("t3_reads", 256'(rd_n - r0), 256'(8));
        chk("t3_first_edge", 256'(rd_edge_q[r0]), 256'(t_edge + 1));
        chk("t3_imports", 256'(imp_n - i0), 256'(1));
        chk("t3_block", o_importedBGBlock, blk1);

        // Full save then reload of block 5 under random ack stalls
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        stall_en = 1'b1;
        i_saveAdr = 15'h0005;
        i_loadAdr = 15'h0005;
        i_exportedMSKBGBlock = 16'hFFFF;
        i_exportedBGBlock = blk4;
        run_cmd(2'b10);
        wait_idle("t4_idle");
        stall_en = 1'b0;
        chk("t4_writes", 256'(wr_n - w0), 256'(8));
        chk("t4_be_all", 256'({wr_be_q[w0], wr_be_q[w0 + 3], wr_be_q[w0 + 7]}), 256'(12'hFFF));
        chk("t4_wadr_last", 256'(wr_adr_q[w0 + 7]), 256'(18'h2F));
        chk("t4_reads", 256'(rd_n - r0), 256'(8));
        chk("t4_imports", 256'(imp_n - i0), 256'(1));
        chk("t4_block", o_importedBGBlock, blk4);
        chk("t4_stable", 256'(stall_err), 256'(0));

        // Code held at 10 for 50 cycles: one operation only
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        i_saveAdr = 15'h0010;
        i_loadAdr = 15'h0041;
        i_exportedMSKBGBlock = 16'h0003;
        @(negedge clk);
        i_saveBGBlock = 2'b10;
        repeat (50) @(negedge clk);
        i_saveBGBlock = 2'b00;
        wait_idle("t5_idle");
        chk("t5_writes", 256'(wr_n - w0), 256'(1));
        chk("t5_wadr", 256'(wr_adr_q[w0]), 256'(18'h80));
        chk("t5_reads", 256'(rd_n - r0), 256'(8));
        chk("t5_imports", 256'(imp_n - i0), 256'(1));

        // 00 -> 11 edge while a load is running
        w0 = wr_n; r0 = rd_n; i0 = imp_n;
        run_cmd(2'b01);
        @(negedge clk);
        i_saveBGBlock = 2'b11;
        #1;
        chk("t6_overrun", 256'(o_errOverrun), 256'(1));
        @(negedge clk);
        chk("t6_overrun_end", 256'(o_errOverrun), 256'(0));
        i_saveBGBlock = 2'b00;
        wait_idle("t6_idle");
        chk("t6_writes", 256'(wr_n - w0), 256'(0));
        chk("t6_reads", 256'(rd_n - r0), 256'(8));
        chk("t6_imports", 256'(imp_n - i0), 256'(1));

        // Reset after the third read ack, then a fresh load of block 5
        r0 = rd_n;
        i_loadAdr = 15'h0041;
        run_cmd(2'b01);
        begin
            int n = 0;
            while (rd_n - r0 < 3 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t7_three_acks", 256'(rd_n - r0 >= 3), 256'(1));
        i_nrst = 1'b0;
        #1;
        chk("t7_req", 256'(o_memReq), 256'(0));
        chk("t7_busy", 256'(o_busy), 256'(0));
        chk("t7_imported", o_importedBGBlock, 256'(0));
        chk("t7_misc", 256'({o_importBGBlockSingleClock, o_errOverrun, o_memWrite,
                             o_memAdr, o_memWdata, o_memBE}), 256'(0));
        repeat (2) @(negedge clk);
        i_nrst = 1'b1;
        @(negedge clk);
        i0 = imp_n; r0 = rd_n;
        i_loadAdr = 15'h0005;
        run_cmd(2'b01);
        wait_idle("t7_idle");
        chk("t7_reads", 256'(rd_n - r0), 256'(8));
        chk("t7_imports", 256'(imp_n - i0), 256'(1));
        chk("t7_block", o_importedBGBlock, blk4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/gpu_bg_block_mover.md
# gpu_bg_block_mover

Memory-side partner of the GPU pixel backend's background-block cache. It watches the backend's 2-bit block operation code (save/load request). On a new request it writes the dirty halfwords of the exported 256-bit block (16 pixels) to VRAM under the 16-bit pixel mask, then reads the next block. The loaded block is handed back through a single-cycle import strobe. It sits between the GPU backend and the VRAM arbiter and holds the pixel pipeline paused while busy.

## Interface
- No parameters. Block = 16 halfwords = 8 × 32-bit words. VRAM word address = {blockAdr[14:0], word[2:0]}.
- clk  in  1  system clock, all logic rising-edge.
- i_nrst  in  1  asynchronous, active-low reset.
- i_saveBGBlock  in  2  operation code from backend: 00 none, 01 first (load only), 10 next (save then load), 11 flush (save only).
- i_saveAdr  in  15  block address to save ({y[8:0], x[9:4]}).
- i_loadAdr  in  15  block address to load.
- i_exportedBGBlock  in  256  block data; pixel p occupies bits [16p+15:16p].
- i_exportedMSKBGBlock  in  16  per-pixel write mask; bit p=1 means pixel p is written.
- o_busy  out  1  request pause of backend pipeline.
- o_importBGBlockSingleClock  out  1  one-cycle strobe: o_importedBGBlock is valid.
- o_importedBGBlock  out  256  loaded block.
- o_errOverrun  out  1  one-cycle pulse: a command edge arrived while not IDLE.
- o_memReq  out  1  memory request valid.
- o_memWrite  out  1  1 = write, 0 = read.
- o_memAdr  out  18  32-bit word address.
- o_memWdata  out  32  write data.
- o_memBE  out  4  byte enables (write only).
- i_memAck  in  1  request accepted this cycle.
- i_memRdValid  in  1  one read word returned this cycle, in request order.
- i_memRdata  in  32  read data.

## Operation
- Trigger: prevCode register holds last i_saveBGBlock (reset 00). trigger = (i_saveBGBlock != 00) & (prevCode == 00).
- On trigger in IDLE: capture the code, both addresses, data and mask into internal registers. The backend may change its inputs afterwards.
- States: IDLE, SAVE, LOAD_REQ, LOAD_WAIT, IMPORT.
- IDLE → SAVE for codes 10/11; IDLE → LOAD_REQ for code 01.
- SAVE:
  - Iterate word k = 0..7 using {m[2k+1], m[2k]}.
  - Words with mask 00 are skipped at zero cycle cost (priority search over remaining words).
  - Otherwise issue a write: adr = {saveAdr, k}; data = words [32k+31:32k]; BE = {m[2k+1], m[2k+1], m[2k], m[2k]}.
  - A fully zero mask skips SAVE entirely.
  - SAVE done → LOAD_REQ for code 10, → IDLE for code 11.
- LOAD_REQ: issue 8 reads, adr = {loadAdr, 0..7}; → LOAD_WAIT after the 8th ack.
- Returned reads:
  - Counted by a 3-bit beat counter; beat n is stored in o_importedBGBlock[32n+31:32n].
  - Beats are accepted in both LOAD_REQ and LOAD_WAIT, since returns may overlap issue.
  - The 8th beat → IMPORT.
- IMPORT: assert o_importBGBlockSingleClock for 1 cycle → IDLE. o_importedBGBlock then holds until the next load completes.
- Save-before-load ordering guarantees that saveAdr == loadAdr reads back the just-written data.
- o_busy = trigger | (state != IDLE).
- Trigger while not IDLE: the command is dropped and o_errOverrun pulses; prevCode still updates.

## Timing
- Reset values: all outputs 0, state IDLE, prevCode 00, counters 0, o_importedBGBlock 0.
- Reset mid-operation: immediate abort. Outstanding read returns after reset release are ignored until a new LOAD_REQ. The arbiter shares this reset.
- Handshake:
  - o_memReq/o_memWrite/o_memAdr/o_memWdata/o_memBE are registered and held stable until a cycle with i_memAck=1.
  - The next request may be presented in the cycle after the ack (back-to-back, 1 beat/cycle).
  - i_memAck without o_memReq is ignored.
- Latency, with the trigger sampled at edge T, acks at zero wait, and read data 1 cycle after ack:
  - First request is driven from T+1.
  - Code 01: reads at T+1..T+8, data T+2..T+9, import strobe at T+10.
  - Code 10 with w active words: writes at T+1..T+w, then reads start at T+w+1.
  - Code 11: back to IDLE (o_busy low) the cycle after the last write ack.
- o_busy falls in the cycle after IMPORT (codes 01/10) or after the last write ack (code 11).

## Test plan
- Code 01, loadAdr=0x0041, memory word i = 0x1111_1111·i → 8 reads at adr 0x00208..0x0020F; import strobe once at T+10; o_importedBGBlock[63:32] = 0x11111111.
- Code 11, saveAdr=0x0003, mask 0x8001 → exactly 2 writes: adr 0x18 with BE 0011, then adr 0x1F with BE 1100; no reads; no import strobe.
- Code 10, mask 0x0000, loadAdr=saveAdr → no writes, 8 reads, import strobe.
- Code 10, mask 0xFFFF, saveAdr=loadAdr=5, random i_memAck stalls → 8 writes with BE 1111, then reads return the written data; outputs stay stable during stalls.
- Code held at 10 for 50 cycles → exactly one operation; a 00→11 edge while busy → o_errOverrun pulses, no extra memory traffic.
- i_nrst asserted after the 3rd read ack → all outputs 0 immediately; a new 01 command after release completes normally with fresh data.
